// File: rtl/peripheral_mpram_pkg.sv
// MPRAM peripheral shared types and address-split helpers.
// Used by peripheral_mpram_multiport_tl and its round-robin arbiter.
package peripheral_mpram_pkg;

  localparam int PORTS_MAX = 8;
  localparam int PLEN_MAX  = 64;
  localparam int XLEN_MAX  = 512;

  function automatic int lsb_f(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  function automatic int aw_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic                  we;
    logic [XLEN_MAX/8-1:0] be;
    logic [PLEN_MAX-1:0]   addr;
    logic [XLEN_MAX-1:0]   data;
  } mpram_req_t;

endpackage

// File: rtl/peripheral_mpram_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search from rr_ptr.
// rr_ptr advances past the winner; holds when idle.
module peripheral_mpram_rr_arbiter
  import peripheral_mpram_pkg::*;
#(
  parameter  int PORTS = 2,
  localparam int IW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req,
  output logic [PORTS-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_vld
);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_nxt;
  int            p;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    p       = 0;
    for (int i = 0; i < PORTS; i++) begin
      p = (int'(rr_ptr) + i) % PORTS;
      if (!gnt_vld && req[p]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(p);
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (gnt_vld) begin
      if (int'(gnt_idx) == PORTS - 1)
        rr_nxt = '0;
      else
        rr_nxt = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr <= '0;
    else      rr_ptr <= rr_nxt;
  end

  logic unused_pkg;
  assign unused_pkg = (PORTS > PORTS_MAX);

endmodule

// File: rtl/peripheral_mpram_multiport_tl.sv
// N-port shared RAM: round-robin onto one DEPTH x XLEN array, byte-lane writes.
// PERIPHERAL_MPRAM_OUTREG_EN adds an output register (latency 2 instead of 1).
module peripheral_mpram_multiport_tl
  import peripheral_mpram_pkg::*;
#(
  parameter int PLEN  = 64,
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024,
  parameter int PORTS = 2
) (
  input  logic                    rst,
  input  logic                    clk,
  input  logic [PORTS-1:0]        req_valid_i,
  output logic [PORTS-1:0]        req_ready_o,
  input  logic [PORTS-1:0]        req_we_i,
  input  logic [PORTS*XLEN/8-1:0] req_be_i,
  input  logic [PORTS*PLEN-1:0]   req_addr_i,
  input  logic [PORTS*XLEN-1:0]   req_data_i,
  output logic [PORTS-1:0]        rsp_valid_o,
  output logic [PORTS-1:0]        rsp_err_o,
  output logic [PORTS*XLEN-1:0]   rsp_data_o
);

  localparam int BW  = XLEN / 8;
  localparam int LSB = lsb_f(XLEN);
  localparam int AW  = aw_f(DEPTH);
  localparam int IW  = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0] req_m;
  logic [PORTS-1:0] gnt;
  logic [IW-1:0]    gidx;
  logic             gvld;

  // no grants while reset is held
  assign req_m = req_valid_i & {PORTS{rst}};

  peripheral_mpram_rr_arbiter #(
    .PORTS(PORTS)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_m),
    .gnt    (gnt),
    .gnt_idx(gidx),
    .gnt_vld(gvld)
  );

  assign req_ready_o = gnt;

  mpram_req_t sel;

  always_comb begin
    sel                 = '0;
    sel.we              = req_we_i[gidx];
    sel.be[BW-1:0]      = req_be_i[gidx*BW +: BW];
    sel.addr[PLEN-1:0]  = req_addr_i[gidx*PLEN +: PLEN];
    sel.data[XLEN-1:0]  = req_data_i[gidx*XLEN +: XLEN];
  end

  logic unused_sel;
  assign unused_sel = ^sel;

  logic [AW-1:0] idx;
  logic          in_rng;

  assign idx    = sel.addr[AW+LSB-1:LSB];
  assign in_rng = ({1'b0, idx} < (AW+1)'(DEPTH));

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (gvld && in_rng) begin
      if (sel.we) begin
        for (int b = 0; b < BW; b++) begin
          if (sel.be[b]) mem[idx][b*8 +: 8] <= sel.data[b*8 +: 8];
        end
      end else begin
        rd_q <= mem[idx];
      end
    end
  end

  logic [PORTS-1:0] s1_vld;
  logic             s1_err;
  logic             s1_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= '0;
      s1_err <= 1'b0;
      s1_rd  <= 1'b0;
    end else begin
      s1_vld <= gnt;
      s1_err <= gvld && !in_rng;
      s1_rd  <= gvld && !sel.we && in_rng;
    end
  end

  logic [PORTS-1:0]      r_vld;
  logic [PORTS-1:0]      r_err;
  logic [PORTS*XLEN-1:0] r_data;

  always_comb begin
    r_vld  = s1_vld;
    r_err  = '0;
    r_data = '0;
    for (int q = 0; q < PORTS; q++) begin
      if (s1_vld[q]) begin
        r_err[q] = s1_err;
        if (s1_rd) r_data[q*XLEN +: XLEN] = rd_q;
      end
    end
  end

`ifdef PERIPHERAL_MPRAM_OUTREG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_o <= '0;
      rsp_err_o   <= '0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= r_vld;
      rsp_err_o   <= r_err;
      rsp_data_o  <= r_data;
    end
  end
`else
  assign rsp_valid_o = r_vld;
  assign rsp_err_o   = r_err;
  assign rsp_data_o  = r_data;
`endif

endmodule

// File: tb/tb_peripheral_mpram_multiport_tl.sv
// Scoreboard bench for peripheral_mpram_multiport_tl (PORTS=2, DEPTH=1000).
// Honours PERIPHERAL_MPRAM_OUTREG_EN for the expected latency.
module tb_peripheral_mpram_multiport_tl;

  localparam int PLEN  = 64;
  localparam int XLEN  = 64;
  localparam int DEPTH = 1000;
  localparam int PORTS = 2;
`ifdef PERIPHERAL_MPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_we;
  logic [15:0]  req_be;
  logic [127:0] req_addr;
  logic [127:0] req_data;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_err;
  logic [127:0] rsp_data;

  always #5 clk = ~clk;

  peripheral_mpram_multiport_tl #(
    .PLEN(PLEN), .XLEN(XLEN), .DEPTH(DEPTH), .PORTS(PORTS)
  ) dut (
    .rst        (rst),
    .clk        (clk),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_be_i   (req_be),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .rsp_valid_o(rsp_valid),
    .rsp_err_o  (rsp_err),
    .rsp_data_o (rsp_data)
  );

  typedef struct {
    int          port;
    logic        err;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mdl [int];
  int          rr_m     = 0;
  int          cyc      = 0;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [7:0] be,
                         input logic [63:0] addr, input logic [63:0] data);
    req_valid[p]        = 1'b1;
    req_we[p]           = we;
    req_be[p*8 +: 8]    = be;
    req_addr[p*64 +: 64] = addr;
    req_data[p*64 +: 64] = data;
  endtask

  task automatic clr(input int p);
    req_valid[p] = 1'b0;
  endtask

  task automatic tick();
    exp_t         e;
    logic [1:0]   ev;
    logic [1:0]   ee;
    logic [1:0]   eg;
    logic [127:0] ed;
    logic [63:0]  a;
    logic [63:0]  w;
    int           g;
    int           idx;
    @(negedge clk);
    ev = '0;
    ee = '0;
    ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ev[e.port]          = 1'b1;
      ee[e.port]          = e.err;
      ed[e.port*64 +: 64] = e.data;
    end
    chk("rsp_valid", 128'(rsp_valid), 128'(ev));
    chk("rsp_err", 128'(rsp_err), 128'(ee));
    chk("rsp_data", rsp_data, ed);
    g  = -1;
    eg = '0;
    for (int i = 0; i < 2; i++) begin
      int p;
      p = (rr_m + i) % 2;
      if (g < 0 && req_valid[p]) g = p;
    end
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", 128'(req_ready), 128'(eg));
    if (g >= 0) begin
      rr_m   = (g + 1) % 2;
      a      = req_addr[g*64 +: 64];
      idx    = int'((a >> 3) & 64'h3FF);
      e.port = g;
      e.due  = cyc + LAT;
      e.err  = (idx >= DEPTH);
      e.data = '0;
      if (!e.err) begin
        if (req_we[g]) begin
          w = mdl.exists(idx) ? mdl[idx] : 'x;
          for (int b = 0; b < 8; b++)
            if (req_be[g*8+b]) w[b*8 +: 8] = req_data[g*64+b*8 +: 8];
          mdl[idx] = w;
        end else begin
          e.data = mdl.exists(idx) ? mdl[idx] : 'x;
        end
      end
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_rsp_valid", 128'(rsp_valid), '0);
    chk("rst_rsp_err", 128'(rsp_err), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_ready", 128'(req_ready), '0);
    q.delete();
    rr_m = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid = '0;
  endtask

  initial begin
    req_valid = '0;
    req_we    = '0;
    req_be    = '0;
    req_addr  = '0;
    req_data  = '0;
    @(posedge clk);
    do_reset();

    // write then read back through port 0
    set_req(0, 1'b1, 8'hFF, 64'h10, 64'h1122334455667788);
    tick(); clr(0); tick();
    set_req(0, 1'b0, 8'hFF, 64'h10, 64'h0);
    tick(); clr(0); tick(); tick();

    // partial byte-lane write and be=0 no-op
    set_req(1, 1'b1, 8'hFF, 64'h18, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(); clr(1);
    set_req(1, 1'b1, 8'h0F, 64'h18, 64'h0);
    tick(); clr(1);
    set_req(1, 1'b0, 8'h00, 64'h18, 64'h0);
    tick(); clr(1);
    set_req(1, 1'b1, 8'h00, 64'h18, 64'hDEAD_BEEF_0BAD_F00D);
    tick(); clr(1);
    set_req(1, 1'b0, 8'h00, 64'h18, 64'h0);
    tick(); clr(1); tick(); tick();

    // out-of-range and upper-address aliasing
    set_req(1, 1'b0, 8'hFF, 64'h1F40, 64'h0);
    tick(); clr(1);
    set_req(1, 1'b1, 8'hFF, 64'h1F40, 64'hAAAA_5555_AAAA_5555);
    tick(); clr(1);
    set_req(0, 1'b0, 8'hFF, 64'h1FF8, 64'h0);
    tick(); clr(0);
    set_req(0, 1'b0, 8'hFF, 64'hFFFF_0000_0000_2010, 64'h0);
    tick(); clr(0); tick(); tick();

    // continuous contention alternates grants
    do_reset();
    set_req(0, 1'b0, 8'hFF, 64'h10, 64'h0);
    set_req(1, 1'b0, 8'hFF, 64'h18, 64'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_alt", 128'(req_ready), (k % 2 == 0) ? 128'h1 : 128'h2);
      tick();
    end
    clr(0); clr(1); tick(); tick(); tick();

    // reset right after an accept drops the response
    set_req(0, 1'b0, 8'hFF, 64'h10, 64'h0);
    tick(); clr(0);
    do_reset();
    tick();
    set_req(0, 1'b0, 8'hFF, 64'h10, 64'h0);
    set_req(1, 1'b0, 8'hFF, 64'h18, 64'h0);
    #1;
    chk("post_rst_first", 128'(req_ready), 128'h1);
    tick(); clr(0); clr(1);
    for (int k = 0; k < 4; k++) tick();

    chk("queue_empty", 128'(q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
